// File: rtl/aec_pkg.sv
// rtl/aec_pkg.sv - shared types, ALU opcodes and token decode for the postfix evaluator
package aec_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    ISSUE  = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    TK_DIGIT = 2'd0,
    TK_OP    = 2'd1,
    TK_EQ    = 2'd2,
    TK_BAD   = 2'd3
  } tok_kind_t;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_A     = 8'h61;
  localparam logic [7:0] CH_F     = 8'h66;
  localparam logic [7:0] CH_PLUS  = 8'h2b;
  localparam logic [7:0] CH_MINUS = 8'h2d;
  localparam logic [7:0] CH_STAR  = 8'h2a;
  localparam logic [7:0] CH_EQ    = 8'h3d;

  function automatic tok_kind_t tok_kind(input logic [7:0] c);
    if ((c >= CH_0 && c <= CH_9) || (c >= CH_A && c <= CH_F)) return TK_DIGIT;
    if (c == CH_PLUS || c == CH_MINUS || c == CH_STAR) return TK_OP;
    if (c == CH_EQ) return TK_EQ;
    return TK_BAD;
  endfunction

  // '0'-'9' carry their value in the low nibble; 'a'-'f' sit at low nibble 1-6.
  function automatic logic [3:0] tok_digit(input logic [7:0] c);
    return c[3:0] + ((c >= CH_A) ? 4'd9 : 4'd0);
  endfunction

  function automatic alu_op_t tok_op(input logic [7:0] c);
    case (c)
      CH_MINUS: return ALU_SUB;
      CH_STAR:  return ALU_MUL;
      default:  return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/aec_stack.sv
// rtl/aec_stack.sv - DEPTH x W operand stack with push, double pop and top/next read
module aec_stack
  import aec_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 7,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop2,
  output logic [CW-1:0] count,
  output logic [W-1:0]  top,
  output logic [W-1:0]  next
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] cnt;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] idx_top;
  logic [AW-1:0] idx_next;
  logic          do_push;

  assign do_push = push && !clear && !pop2 && (cnt != FULL);

  // Underflowing pops saturate at empty; the missing operands read as 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (pop2) begin
      cnt <= (cnt >= CW'(2)) ? cnt - CW'(2) : '0;
    end else if (do_push) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[cnt[AW-1:0]] <= push_data;
  end

  assign idx_top  = cnt[AW-1:0] - AW'(1);
  assign idx_next = cnt[AW-1:0] - AW'(2);
  assign count    = cnt;
  assign top      = (cnt >= CW'(1)) ? mem[idx_top]  : '0;
  assign next     = (cnt >= CW'(2)) ? mem[idx_next] : '0;

endmodule

// File: rtl/aec_eval_ctrl.sv
// rtl/aec_eval_ctrl.sv - postfix expression evaluator driving a shared ALU
// Define AEC_ERR_EN to trap overflow, underflow, bad '=' and illegal tokens.
module aec_eval_ctrl
  import aec_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  input  logic [7:0]   tok_data,
  output logic         tok_ready,
  output logic         alu_req,
  output logic [1:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic         alu_ack,
  input  logic [W-1:0] alu_res,
  output logic         valid,
  output logic [W-1:0] result,
  output logic         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        state, state_nx;
  tok_kind_t     kind;
  logic          xfer;
  logic          bad_tok;
  logic          full;
  logic          stk_clear;
  logic          stk_push;
  logic          stk_pop2;
  logic [W-1:0]  stk_din;
  logic [CW-1:0] stk_count;
  logic [W-1:0]  stk_top;
  logic [W-1:0]  stk_next;

  assign kind = tok_kind(tok_data);
  assign xfer = tok_valid && (state == ACCEPT);
  assign full = (stk_count == FULL);

`ifdef AEC_ERR_EN
  logic err_q;

  always_comb begin
    bad_tok = 1'b0;
    case (kind)
      TK_DIGIT: bad_tok = full;
      TK_OP:    bad_tok = (stk_count < CW'(2));
      TK_EQ:    bad_tok = (stk_count != CW'(1));
      default:  bad_tok = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else if (state_nx == ERROR) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign bad_tok = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    stk_clear = 1'b0;
    stk_push  = 1'b0;
    stk_pop2  = 1'b0;
    stk_din   = W'(tok_digit(tok_data));
    tok_ready = 1'b0;
    alu_req   = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        stk_clear = 1'b1;
        state_nx  = ACCEPT;
      end
      ACCEPT: begin
        tok_ready = 1'b1;
        if (xfer) begin
          if (bad_tok) begin
            state_nx = ERROR;
          end else begin
            case (kind)
              TK_DIGIT: stk_push = !full;
              TK_OP: begin
                stk_pop2 = 1'b1;
                state_nx = ISSUE;
              end
              TK_EQ:    state_nx = DONE;
              default:  ;
            endcase
          end
        end
      end
      ISSUE: begin
        alu_req = 1'b1;
        if (alu_ack) begin
          stk_push = 1'b1;
          stk_din  = alu_res;
          state_nx = ACCEPT;
        end
      end
      DONE: begin
        valid    = 1'b1;
        state_nx = IDLE;
      end
      ERROR:   state_nx = ERROR;
      default: state_nx = IDLE;
    endcase
  end

  // Operands are captured at the pop so they stay frozen for the whole request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_op <= 2'd0;
      alu_a  <= '0;
      alu_b  <= '0;
      result <= '0;
    end else if (xfer && !bad_tok) begin
      if (kind == TK_OP) begin
        alu_op <= tok_op(tok_data);
        alu_a  <= stk_next;
        alu_b  <= stk_top;
      end
      if (kind == TK_EQ) result <= stk_top;
    end
  end

  aec_stack #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (stk_clear),
    .push      (stk_push),
    .push_data (stk_din),
    .pop2      (stk_pop2),
    .count     (stk_count),
    .top       (stk_top),
    .next      (stk_next)
  );

endmodule
